fft_8_sdf_ctrl: RTL and testbench
=================================

FFT_8_SDF_CTRL -- requirements
Module: fft_8_sdf_ctrl

Interface
REQ-001 SHALL have parameter STAGE_LAT, default 1, pipeline registers per datapath stage (legal 0..3).
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  source presents one complex sample this cycle.
REQ-005 SHALL have port in_ready  output  1  controller accepts sample (transfer = in_valid & in_ready).
REQ-006 SHALL have port dp_en  output  1  global datapath advance enable.
REQ-007 SHALL have port zero_in  output  1  datapath substitutes 0+j0 for input sample.
REQ-008 SHALL have ports s1_sel, s2_sel, s3_sel  output  1 each  1 = butterfly phase, 0 = fill/drain phase for stage 1/2/3.
REQ-009 SHALL have port tw1_idx  output  2  stage-1 twiddle index k of W8^k.
REQ-010 SHALL have port tw2_negj  output  1  stage-2 multiply by -j.
REQ-011 SHALL have port out_valid  output  1  datapath output carries a real result this cycle.
REQ-012 SHALL have port out_idx  output  3  natural frequency bin of current output.
REQ-013 SHALL have port out_frame_start  output  1  first output of a frame.
REQ-014 SHALL have port busy  output  1  state != IDLE.

Function
REQ-015 SHALL implement FSM states IDLE, RUN, FLUSH.
REQ-016 SHALL keep master counter m (3 bit, mod 8), incremented on every cycle with dp_en=1.
REQ-017 SHALL derive c1=m, c2=m-(4+STAGE_LAT), c3=m-(6+2*STAGE_LAT), cout=m-LAT, all mod 8, with LAT=7+3*STAGE_LAT (10 at default).
REQ-018 SHALL drive s1_sel=c1[2], s2_sel=c2[1], s3_sel=c3[0]; tw1_idx=c1[1:0] when s1_sel=0 else 0; tw2_negj=~c2[1]&c2[0].
REQ-019 SHALL drive out_idx=bitrev(cout), giving order 0,4,2,6,1,5,3,7 per frame.
REQ-020 SHALL keep LAT-deep valid shift register advancing on dp_en; entry = transfer (1) or flush (0); out_valid = dp_en & tail.
REQ-021 SHALL drive out_frame_start = out_valid & (cout==0).
REQ-022 IDLE: in_ready=1, dp_en=transfer, zero_in=0; transfer -> RUN.
REQ-023 RUN: in_ready=1, dp_en=transfer; in_valid low mid-frame (m!=0) stalls everything (dp_en=0, all state held).
REQ-024 RUN, in_valid=0 at frame boundary (m==0) and shift register non-empty -> FLUSH.
REQ-025 FLUSH: dp_en=1, zero_in=1, in_ready=(m==0); transfer at m==0 -> RUN with that sample counted real.
REQ-026 FLUSH -> IDLE when shift register empty and m==0; dp_en=0 in IDLE thereafter.
REQ-027 Back-to-back frames SHALL run with no bubble; every output of a frame SHALL be contiguous unless input stalls.

Reset
REQ-028 Reset asserted SHALL force state=IDLE, m=0, shift register cleared, all outputs 0 except in_ready=1, immediately (asynchronous).
REQ-029 Reset mid-frame SHALL discard partial frame; no out_valid until a new full input frame has traversed LAT enabled cycles.

Structure
REQ-030 SHALL place FSM state encoding, N=8, LOG2N=3 and LAT formula in shared package fft_8_sdf_pkg.
REQ-031 SHALL be one module, no sub-modules; bitrev is an inline function.

Verification
REQ-032 One frame of 8 valid samples, STAGE_LAT=1 -> first out_valid 10 enabled cycles after first transfer, 8 outputs, out_idx 0,4,2,6,1,5,3,7, then IDLE.
REQ-033 Three back-to-back frames (24 consecutive transfers) -> 24 contiguous out_valid, out_frame_start at outputs 0,8,16.
REQ-034 in_valid low 3 cycles after sample 5 -> dp_en=0 and sel/tw/out signals frozen 3 cycles, results otherwise identical to REQ-032.
REQ-035 in_valid raised during FLUSH at m=3 -> in_ready=0 until m==0, then accepted, state RUN, no lost or duplicated output.
REQ-036 rst low at sample 4 -> all outputs reset values within same cycle; subsequent frame gives REQ-032 response exactly.
REQ-037 Sweep STAGE_LAT 0..3 -> first-output latency 7,10,13,16 and s1/s2/s3 phase patterns 4/4, 2/2, 1/1 per frame.

Source files
------------

// File: rtl/fft_8_sdf_pkg.sv
// Shared constants and types for the 8-point single-path delay-feedback FFT controller.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fft_8_sdf_pkg;

  localparam int N     = 8;
  localparam int LOG2N = 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_t;

  // End-to-end datapath latency in enabled cycles: three butterfly stages of
  // 4/2/1 delay-line depth plus the per-stage pipeline registers.
  function automatic int calc_lat(input int stage_lat);
    return 7 + 3 * stage_lat;
  endfunction

endpackage

// File: rtl/fft_8_sdf_ctrl.sv
// Control sequencer for an 8-point radix-2 SDF FFT: stage muxes, twiddles, output tagging.
// Latency: controls are combinational from state; a sample's result emerges LAT enabled cycles after transfer.
// Backpressure: in_valid low mid-frame freezes the whole pipe; during flush new frames are accepted only on a frame boundary.
module fft_8_sdf_ctrl
  import fft_8_sdf_pkg::*;
#(
  parameter int STAGE_LAT = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  output logic       dp_en,
  output logic       zero_in,
  output logic       s1_sel,
  output logic       s2_sel,
  output logic       s3_sel,
  output logic [1:0] tw1_idx,
  output logic       tw2_negj,
  output logic       out_valid,
  output logic [2:0] out_idx,
  output logic       out_frame_start,
  output logic       busy
);

  localparam int LAT = calc_lat(STAGE_LAT);

  // Stage offsets relative to the master counter. Stage 2 only ever looks at
  // its two low bits and stage 3 only at its LSB, so the offsets are kept at
  // exactly those widths (subtraction modulo 4 / modulo 2 preserves the low bits).
  localparam logic [1:0]       OFF2 = 2'((4 + STAGE_LAT) % 4);
  localparam logic             OFF3 = 1'((6 + 2 * STAGE_LAT) % 2);
  localparam logic [LOG2N-1:0] OFFO = LOG2N'(LAT % N);

  state_t           state;
  logic [LOG2N-1:0] m;
  logic [LAT-1:0]   vsr;

  logic             rdy_i;
  logic             xfer;
  logic             bnd_flush;
  logic             flush_now;
  logic             adv;
  logic [LOG2N-1:0] m_nxt;
  logic [LAT-1:0]   vsr_nxt;
  logic [LOG2N-1:0] c1;
  logic [1:0]       c2;
  logic             c3;
  logic [LOG2N-1:0] cout;

  // Bit-reversal of the output counter gives the natural frequency bin.
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] v);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) begin
      r[i] = v[LOG2N-1-i];
    end
    return r;
  endfunction

  // Input acceptance: always open except while flushing mid-frame, where a new
  // frame may only start on a frame boundary so its samples line up with m.
  always_comb begin
    rdy_i = 1'b1;
    if (state == FLUSH) begin
      rdy_i = (m == '0);
    end
  end

  assign xfer      = in_valid & rdy_i;
  // A frame boundary with no new input and results still in flight starts the
  // flush in this very cycle, so a frame's outputs never see a bubble.
  assign bnd_flush = (state == RUN) & ~in_valid & (m == '0) & (|vsr);
  assign flush_now = (state == FLUSH) | bnd_flush;
  assign adv       = xfer | flush_now;
  assign m_nxt     = m + 1'b1;
  assign vsr_nxt   = {vsr[LAT-2:0], xfer};

  // Per-stage phase counters, all delayed copies of the master counter.
  assign c1   = m;
  assign c2   = m[1:0] - OFF2;
  assign c3   = m[0] ^ OFF3;
  assign cout = m - OFFO;

  // Master counter and result-valid pipeline advance together with the datapath.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m   <= '0;
      vsr <= '0;
    end else if (adv) begin
      m   <= m_nxt;
      vsr <= vsr_nxt;
    end
  end

  // Frame-level FSM: idle until a sample arrives, run while input streams,
  // flush zeros until every in-flight result has left and m has wrapped.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (xfer) begin
            state <= RUN;
          end
        end
        RUN: begin
          if (!in_valid && (m == '0)) begin
            state <= (|vsr) ? FLUSH : IDLE;
          end
        end
        FLUSH: begin
          if (xfer) begin
            state <= RUN;
          end else if ((vsr_nxt == '0) && (m_nxt == '0)) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output decode; reset overrides everything so the datapath sees safe values
  // the moment reset is asserted, without waiting for a clock.
  always_comb begin
    in_ready        = 1'b1;
    dp_en           = 1'b0;
    zero_in         = 1'b0;
    s1_sel          = 1'b0;
    s2_sel          = 1'b0;
    s3_sel          = 1'b0;
    tw1_idx         = 2'b00;
    tw2_negj        = 1'b0;
    out_valid       = 1'b0;
    out_idx         = '0;
    out_frame_start = 1'b0;
    busy            = 1'b0;
    if (rst) begin
      in_ready        = rdy_i;
      dp_en           = adv;
      zero_in         = flush_now & ~xfer;
      s1_sel          = c1[2];
      s2_sel          = c2[1];
      s3_sel          = c3;
      tw1_idx         = c1[2] ? 2'b00 : c1[1:0];
      tw2_negj        = ~c2[1] & c2[0];
      out_valid       = adv & vsr[LAT-1];
      out_idx         = bitrev(cout);
      out_frame_start = adv & vsr[LAT-1] & (cout == '0);
      busy            = (state != IDLE);
    end
  end

endmodule

// File: tb/tb_fft_8_sdf_ctrl.sv
// Bench for fft_8_sdf_ctrl: four instances (STAGE_LAT 0..3) on shared stimulus; instance 1 is fully scoreboarded.
// Latency: checks first-output latency and output order against bench-side expectations.
// Backpressure: exercises mid-frame stalls, flush-time input, back-to-back frames and async reset.
`timescale 1ns/1ps
module tb_fft_8_sdf_ctrl;

  logic clk      = 1'b0;
  logic rst      = 1'b0;
  logic in_valid = 1'b0;

  logic [3:0]      rdy_a, dpen_a, zero_a, s1_a, s2_a, s3_a, tw2_a, ov_a, fs_a, busy_a;
  logic [3:0][1:0] tw1_a;
  logic [3:0][2:0] idx_a;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    fft_8_sdf_ctrl #(.STAGE_LAT(g)) dut (
      .clk             (clk),
      .rst             (rst),
      .in_valid        (in_valid),
      .in_ready        (rdy_a[g]),
      .dp_en           (dpen_a[g]),
      .zero_in         (zero_a[g]),
      .s1_sel          (s1_a[g]),
      .s2_sel          (s2_a[g]),
      .s3_sel          (s3_a[g]),
      .tw1_idx         (tw1_a[g]),
      .tw2_negj        (tw2_a[g]),
      .out_valid       (ov_a[g]),
      .out_idx         (idx_a[g]),
      .out_frame_start (fs_a[g]),
      .busy            (busy_a[g])
    );
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // ---------------- scoreboard for instance 1 (STAGE_LAT=1, LAT=10) --------
  typedef struct {
    logic [2:0] idx;
    logic       fs;
    int         due;
  } exp_t;

  exp_t       sbq[$];
  exp_t       e_push, e_pop;
  logic [2:0] brv [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
  int         en_cnt, tx_n, nout, out_first_cyc, out_last_cyc;
  int         cyc = 0;

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      sbq.delete();
      en_cnt = 0;
      tx_n   = 0;
    end else begin
      if (in_valid && rdy_a[1]) begin
        e_push.idx = brv[tx_n % 8];
        e_push.fs  = ((tx_n % 8) == 0);
        e_push.due = en_cnt + 10;
        sbq.push_back(e_push);
        tx_n++;
      end
      if (ov_a[1]) begin
        if (sbq.size() == 0) begin
          chk("unexpected_out_valid", 1, 0);
        end else begin
          e_pop = sbq.pop_front();
          chk("out_idx", idx_a[1], e_pop.idx);
          chk("out_frame_start", fs_a[1], e_pop.fs);
          chk("out_latency", en_cnt, e_pop.due);
        end
        if (nout == 0) out_first_cyc = cyc;
        out_last_cyc = cyc;
        nout++;
      end
      if (dpen_a[1]) en_cnt++;
    end
  end

  // ---------------- per-instance latency / phase capture -------------------
  int         en_g[4], first_g[4], nout_g[4];
  logic [7:0] s1p[4], s2p[4], s3p[4], tw2p[4];
  logic [15:0] tw1p[4];

  always @(negedge clk) begin
    for (int g = 0; g < 4; g++) begin
      if (!rst) begin
        en_g[g] = 0; first_g[g] = -1; nout_g[g] = 0;
        s1p[g] = '0; s2p[g] = '0; s3p[g] = '0; tw2p[g] = '0; tw1p[g] = '0;
      end else if (dpen_a[g]) begin
        if (en_g[g] < 8) begin
          s1p[g][en_g[g]]        = s1_a[g];
          s2p[g][en_g[g]]        = s2_a[g];
          s3p[g][en_g[g]]        = s3_a[g];
          tw2p[g][en_g[g]]       = tw2_a[g];
          tw1p[g][2*en_g[g] +: 2] = tw1_a[g];
        end
        if (ov_a[g]) begin
          if (first_g[g] < 0) first_g[g] = en_g[g];
          nout_g[g]++;
        end
        en_g[g]++;
      end
    end
  end

  // ---------------- stimulus tables ----------------------------------------
  typedef struct {
    logic iv;
    int   reps;
    logic rdy, dpen, zero, busy;
  } vec_t;

  typedef struct {
    int          lat;
    logic [7:0]  s1p, s2p, s3p, tw2p;
    logic [15:0] tw1p;
  } sw_t;

  vec_t tbl[7];
  sw_t  sw[4];

  task automatic drive(input logic v);
    @(posedge clk);
    #1 in_valid = v;
    @(negedge clk);
    #1;
  endtask

  task automatic apply_table(input string tag);
    for (int r = 0; r < 7; r++) begin
      for (int k = 0; k < tbl[r].reps; k++) begin
        drive(tbl[r].iv);
        chk($sformatf("%s_row%0d_in_ready", tag, r), rdy_a[1],  tbl[r].rdy);
        chk($sformatf("%s_row%0d_dp_en", tag, r),    dpen_a[1], tbl[r].dpen);
        chk($sformatf("%s_row%0d_zero_in", tag, r),  zero_a[1], tbl[r].zero);
        chk($sformatf("%s_row%0d_busy", tag, r),     busy_a[1], tbl[r].busy);
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    drive(1'b0);
    while (busy_a[1] && k < 200) begin
      drive(1'b0);
      k++;
    end
    chk({tag, "_idle_timeout_busy"}, busy_a[1], 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, rdy_a[1], 1);
    chk({tag, "_dp_en"},    dpen_a[1], 0);
    chk({tag, "_zero_in"},  zero_a[1], 0);
    chk({tag, "_sel"},      {s1_a[1], s2_a[1], s3_a[1]}, 0);
    chk({tag, "_tw"},       {tw1_a[1], tw2_a[1]}, 0);
    chk({tag, "_out"},      {ov_a[1], idx_a[1], fs_a[1]}, 0);
    chk({tag, "_busy"},     busy_a[1], 0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0] = '{1'b1, 1, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{1'b1, 7, 1'b1, 1'b1, 1'b0, 1'b1};
    tbl[2] = '{1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[3] = '{1'b0, 7, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[4] = '{1'b0, 1, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[5] = '{1'b0, 7, 1'b0, 1'b1, 1'b1, 1'b1};
    tbl[6] = '{1'b0, 3, 1'b1, 1'b0, 1'b0, 1'b0};

    sw[0] = '{7,  8'hF0, 8'hCC, 8'hAA, 8'h22, 16'h00E4};
    sw[1] = '{10, 8'hF0, 8'h99, 8'hAA, 8'h44, 16'h00E4};
    sw[2] = '{13, 8'hF0, 8'h33, 8'hAA, 8'h88, 16'h00E4};
    sw[3] = '{16, 8'hF0, 8'h66, 8'hAA, 8'h11, 16'h00E4};

    // reset state
    #1;
    chk_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;

    // single frame, then latency and phase sweep across all instances
    nout = 0;
    apply_table("frame1");
    chk("frame1_outputs", nout, 8);
    chk("frame1_sb_empty", sbq.size(), 0);
    for (int g = 0; g < 4; g++) begin
      chk($sformatf("sweep%0d_latency", g), first_g[g], sw[g].lat);
      chk($sformatf("sweep%0d_nout", g),    nout_g[g],  8);
      chk($sformatf("sweep%0d_s1", g),      s1p[g],     sw[g].s1p);
      chk($sformatf("sweep%0d_s2", g),      s2p[g],     sw[g].s2p);
      chk($sformatf("sweep%0d_s3", g),      s3p[g],     sw[g].s3p);
      chk($sformatf("sweep%0d_tw1", g),     tw1p[g],    sw[g].tw1p);
      chk($sformatf("sweep%0d_tw2", g),     tw2p[g],    sw[g].tw2p);
    end

    // three back-to-back frames
    nout = 0;
    for (int i = 0; i < 24; i++) drive(1'b1);
    wait_idle("b2b");
    chk("b2b_outputs", nout, 24);
    chk("b2b_contiguous", out_last_cyc - out_first_cyc + 1, 24);
    chk("b2b_sb_empty", sbq.size(), 0);

    // three-cycle input stall after sample 5 (m held at 6)
    nout = 0;
    for (int i = 0; i < 6; i++) drive(1'b1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0);
      chk("stall_dp_en",     dpen_a[1], 0);
      chk("stall_out_valid", ov_a[1],   0);
      chk("stall_in_ready",  rdy_a[1],  1);
      chk("stall_sel",       {s1_a[1], s2_a[1], s3_a[1]}, 3'b100);
      chk("stall_tw1",       tw1_a[1], 0);
      chk("stall_tw2",       tw2_a[1], 1);
      chk("stall_out_idx",   idx_a[1], 1);
    end
    drive(1'b1);
    drive(1'b1);
    wait_idle("stall");
    chk("stall_outputs", nout, 8);
    chk("stall_sb_empty", sbq.size(), 0);

    // new frame offered during flush at m=3
    nout = 0;
    for (int i = 0; i < 8; i++) drive(1'b1);
    for (int i = 0; i < 3; i++) drive(1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(1'b1);
      chk("flush_in_ready_blocked", rdy_a[1],  0);
      chk("flush_dp_en",            dpen_a[1], 1);
      chk("flush_zero_in",          zero_a[1], 1);
    end
    drive(1'b1);
    chk("flush_accept_in_ready", rdy_a[1], 1);
    chk("flush_accept_zero_in",  zero_a[1], 0);
    for (int i = 0; i < 7; i++) begin
      drive(1'b1);
      chk("flush_run_zero_in", zero_a[1], 0);
      chk("flush_run_busy",    busy_a[1], 1);
      chk("flush_run_ready",   rdy_a[1],  1);
    end
    wait_idle("flush");
    chk("flush_outputs", nout, 16);
    chk("flush_sb_empty", sbq.size(), 0);

    // asynchronous reset while sample 4 is being offered
    for (int i = 0; i < 4; i++) drive(1'b1);
    @(posedge clk);
    #1 in_valid = 1'b1;
    #2 rst = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1 rst = 1'b1;
    in_valid = 1'b0;
    nout = 0;
    apply_table("postrst");
    chk("postrst_outputs", nout, 8);
    chk("postrst_sb_empty", sbq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
